mac_dot_arbiter: RTL
====================

Name: mac_dot_arbiter

Overview:
- Shares one signed multiply-accumulate datapath between two requesters.
- Each requester submits a 4-element signed dot product, Y = sum(A[k]*B[k]) for k = 0..3.
- The block arbitrates round-robin, sequences the four MAC iterations, then returns the result with a per-requester acknowledge.
- Sits between vector-producing clients and the single MAC so that only one MAC instance exists in the design.

Parameters:
- N, 8, element width in bits (signed two's complement); result width is 2*N+2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req0  input  1  requester 0 request; level, held until ack0.
- a_vec0  input  4*N  requester 0 A vector; element k at bits [N*k+N-1 : N*k].
- b_vec0  input  4*N  requester 0 B vector; same packing.
- req1  input  1  requester 1 request.
- a_vec1  input  4*N  requester 1 A vector.
- b_vec1  input  4*N  requester 1 B vector.
- ack0  output  1  one-cycle pulse; requester 0 result valid on y.
- ack1  output  1  one-cycle pulse; requester 1 result valid on y.
- y  output  2*N+2  signed dot-product result; holds its value until the next result.
- resp_id  output  1  id of the requester owning y.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. ack0, ack1, y, resp_id, busy, the accumulator, the count and the latched vectors all go to 0. last_id goes to 1, so req0 wins the first tie.
- States: IDLE, RUN, DONE.
- IDLE, at each edge:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the id != last_id.
  - On a grant: latch that requester's a_vec and b_vec into internal registers, set gnt_id, acc <= 0, cnt <= 0, state <= RUN.
  - Vectors are sampled only at the grant edge. Later input changes are ignored.
- RUN, at each edge:
  - acc <= acc + sext(A[cnt]) * sext(B[cnt]), with a full-precision signed product of 2*N bits, sign-extended to 2*N+2; then cnt <= cnt+1.
  - At the edge where cnt == 3: y <= acc + product, resp_id <= gnt_id, ack[gnt_id] <= 1, last_id <= gnt_id, state <= DONE.
- DONE: lasts exactly one cycle with ack[gnt_id] high. At the next edge, ack <= 0 and state <= IDLE.
- Latency: grant edge E0; accumulation at E1..E3; result and ack registered at E4; ack high for the cycle E4..E5. IDLE samples again at E6 at the earliest.
- Throughput: one dot product per 6 cycles under back-to-back requests.
- Handshake:
  - A requester drops req on the edge that ends its ack cycle (E5).
  - A req still high in IDLE after that is treated as a new request.
  - A requester must not drop req before its ack. If it does, the operation still completes and ack is still issued.
- Width: 2*N+2 bits cannot overflow for 4 terms. Worst case (-2^(N-1))^2 * 4 = 2^(2N) < 2^(2N+1).
- Simultaneous events:
  - A req arriving during RUN/DONE waits in IDLE; there is no queue beyond the level request.
  - Both requesters are never acked in the same cycle.
- Reset mid-operation: the operation is aborted, no ack is issued, and y is cleared.
- ack0 and ack1 are mutually exclusive, and each is only ever high in DONE.

Test Plan:
- req0 only, A=(1,2,3,4), B=(5,6,7,8) -> ack0 pulse exactly 4 edges after the grant edge, y=70 (0x00046), resp_id=0, busy high 5 cycles.
- req1 only, A=(-1,2,-3,4), B=(5,-6,7,-8) -> y=-70 (0x3FFBA), ack1 single cycle, ack0 stays 0.
- Extremes, N=8:
  - All A=B=-128 -> y=65536 (0x10000).
  - A=-128, B=127 in every element -> y=-65024 (0x30200).
- req0 and req1 asserted together after reset, both held until acked -> req0 served first, then req1 granted at E6. Both new results are correct, and ack0/ack1 are never high together.
- Both requests held continuously -> grants alternate 0,1,0,1. Changing a_vec0 during req0's RUN does not alter its result.
- rst pulsed low during RUN (cnt=2) -> outputs go to 0 immediately and no ack appears. After release, a new request completes normally.

Source files
------------

// File: rtl/mac_dot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_arbiter
// Purpose  : Round-robin sharing of one signed MAC between two requesters,
//            each computing a 4-element signed dot product.
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_arbiter #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [4*N-1:0]   a_vec0,
    input  logic [4*N-1:0]   b_vec0,
    input  logic             req1,
    input  logic [4*N-1:0]   a_vec1,
    input  logic [4*N-1:0]   b_vec1,
    output logic             ack0,
    output logic             ack1,
    output logic [2*N+1:0]   y,
    output logic             resp_id,
    output logic             busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]            r_state;
    logic                  r_gnt_id;
    logic                  r_last_id;
    logic [1:0]            r_cnt;
    logic [2*N+1:0]        r_acc;
    logic [4*N-1:0]        r_a;
    logic [4*N-1:0]        r_b;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [2*N+1:0]        r_y;
    logic                  r_resp_id;

    logic signed [N-1:0]   w_a_elem [4];
    logic signed [N-1:0]   w_b_elem [4];
    logic signed [2*N-1:0] w_a_ext;
    logic signed [2*N-1:0] w_b_ext;
    logic signed [2*N-1:0] w_prod;
    logic [2*N+1:0]        w_prod_ext;
    logic [2*N+1:0]        w_sum;
    logic                  w_any_req;
    logic                  w_pick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elem
            assign w_a_elem[gi] = r_a[N*gi +: N];
            assign w_b_elem[gi] = r_b[N*gi +: N];
        end
    endgenerate

    // Operands widened before the multiply so the product keeps full precision.
    assign w_a_ext    = {{N{w_a_elem[r_cnt][N-1]}}, w_a_elem[r_cnt]};
    assign w_b_ext    = {{N{w_b_elem[r_cnt][N-1]}}, w_b_elem[r_cnt]};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{2{w_prod[2*N-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // On a tie the requester that was not served last wins.
    assign w_any_req = req0 | req1;
    assign w_pick    = (req0 && req1) ? ~r_last_id : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_gnt_id  <= 1'b0;
            r_last_id <= 1'b1;
            r_cnt     <= 2'd0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_y       <= '0;
            r_resp_id <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_gnt_id <= w_pick;
                        r_a      <= w_pick ? a_vec1 : a_vec0;
                        r_b      <= w_pick ? b_vec1 : b_vec0;
                        r_acc    <= '0;
                        r_cnt    <= 2'd0;
                        r_state  <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_y       <= w_sum;
                        r_resp_id <= r_gnt_id;
                        r_ack0    <= ~r_gnt_id;
                        r_ack1    <= r_gnt_id;
                        r_last_id <= r_gnt_id;
                        r_state   <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign y       = r_y;
    assign resp_id = r_resp_id;
    assign busy    = (r_state == c_st_run) || (r_state == c_st_done);

endmodule
`default_nettype wire
